// File: rtl/palette_pkg.sv
// Shared types for the palette lookup pipeline:
// RGB bundle, load FSM states, fallback colour helper.
package palette_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic {
      PL_IDLE,
      PL_LOAD
   } pl_state_t;

   localparam logic TRANSP_NONE = 1'b0;

   // Unloaded palettes show the index as a grey level.
   function automatic rgb_t grey_fallback(input logic [7:0] lvl);
      rgb_t c;
      c.r = lvl;
      c.g = lvl;
      c.b = lvl;
      return c;
   endfunction

endpackage

// File: rtl/palette_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-first on a same-address collision; no reset on the array.
module palette_ram #(
   parameter int AW    = 10,
   parameter int DEPTH = 1024,
   parameter int DW    = 24
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Write and registered read share the edge; old data wins.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/palette_lut_pipe.sv
// Palette lookup: {pal, idx} -> RGB + transparency in two cycles,
// with a streaming load FSM that fills one palette at a time.
module palette_lut_pipe
   import palette_pkg::*;
#(
   parameter  int IDX_W   = 8,
   parameter  int NUM_PAL = 4,
   localparam int PAL_W   = $clog2(NUM_PAL)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               pix_valid_i,
   input  logic [PAL_W-1:0]   pix_pal_i,
   input  logic [IDX_W-1:0]   pix_idx_i,
   output logic               pix_valid_o,
   output logic [23:0]        pix_rgb_o,
   output logic               pix_transp_o,
   input  logic               load_start_i,
   input  logic [PAL_W-1:0]   load_pal_i,
   input  logic [IDX_W-1:0]   load_key_i,
   input  logic               wr_valid_i,
   input  logic [23:0]        wr_rgb_i,
   output logic               wr_ready_o,
   output logic               load_busy_o,
   output logic [NUM_PAL-1:0] pal_loaded_o
);

   localparam int AW    = PAL_W + IDX_W;
   localparam int DEPTH = NUM_PAL * (2 ** IDX_W);
   localparam logic [IDX_W-1:0] LAST = '1;

   pl_state_t        state;
   logic [PAL_W-1:0] cur_pal;
   logic [IDX_W-1:0] addr;
   logic [IDX_W-1:0] key [NUM_PAL];

   logic             look_ok;
   logic             start_ok;
   logic             cur_ok;
   logic [PAL_W-1:0] look_pal;
   logic             beat;
   logic [23:0]      ram_q;

   logic             s1_valid;
   logic             s1_loaded;
   logic [IDX_W-1:0] s1_idx;
   logic [IDX_W-1:0] s1_key;
   rgb_t             fall;

   // Palette ids past NUM_PAL behave as never loaded.
   assign look_ok  = int'(pix_pal_i) < NUM_PAL;
   assign start_ok = int'(load_pal_i) < NUM_PAL;
   assign cur_ok   = int'(cur_pal) < NUM_PAL;
   assign look_pal = look_ok ? pix_pal_i : '0;
   assign beat     = (state == PL_LOAD) && wr_valid_i;
   assign fall     = grey_fallback(8'(s1_idx));

   palette_ram #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .DW    (24)
   ) u_ram (
      .clk   (clk),
      .we    (beat),
      .waddr ({cur_pal, addr}),
      .wdata (wr_rgb_i),
      .raddr ({pix_pal_i, pix_idx_i}),
      .rdata (ram_q)
   );

   // Load FSM: latch palette/key on start, then count beats to the end.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= PL_IDLE;
         cur_pal      <= '0;
         addr         <= '0;
         pal_loaded_o <= '0;
         wr_ready_o   <= 1'b0;
         load_busy_o  <= 1'b0;
         for (int i = 0; i < NUM_PAL; i++) begin
            key[i] <= '0;
         end
      end else begin
         unique case (state)
            PL_IDLE: begin
               if (load_start_i) begin
                  cur_pal     <= load_pal_i;
                  addr        <= '0;
                  state       <= PL_LOAD;
                  wr_ready_o  <= 1'b1;
                  load_busy_o <= 1'b1;
                  if (start_ok) begin
                     key[load_pal_i]          <= load_key_i;
                     pal_loaded_o[load_pal_i] <= 1'b0;
                  end
               end
            end
            PL_LOAD: begin
               if (wr_valid_i) begin
                  addr <= addr + 1'b1;
                  if (addr == LAST) begin
                     state       <= PL_IDLE;
                     wr_ready_o  <= 1'b0;
                     load_busy_o <= 1'b0;
                     if (cur_ok) begin
                        pal_loaded_o[cur_pal] <= 1'b1;
                     end
                  end
               end
            end
            default: state <= PL_IDLE;
         endcase
      end
   end

   // Two-stage lookup; colour/transparency hold while output is idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid     <= 1'b0;
         s1_loaded    <= 1'b0;
         s1_idx       <= '0;
         s1_key       <= '0;
         pix_valid_o  <= 1'b0;
         pix_rgb_o    <= '0;
         pix_transp_o <= 1'b0;
      end else begin
         s1_valid    <= pix_valid_i;
         s1_idx      <= pix_idx_i;
         s1_loaded   <= look_ok & pal_loaded_o[look_pal];
         s1_key      <= key[look_pal];
         pix_valid_o <= s1_valid;
         if (s1_valid) begin
            pix_rgb_o    <= s1_loaded ? ram_q : fall;
            pix_transp_o <= s1_loaded ? (s1_idx == s1_key) : TRANSP_NONE;
         end
      end
   end

endmodule

// File: tb/tb_palette_lut_pipe.sv
// Directed bench for palette_lut_pipe: hand-picked vectors plus a
// cycle model of loads and 2-cycle lookups.
module tb_palette_lut_pipe;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        pix_valid_i;
   logic [1:0]  pix_pal_i;
   logic [7:0]  pix_idx_i;
   logic        pix_valid_o;
   logic [23:0] pix_rgb_o;
   logic        pix_transp_o;
   logic        load_start_i;
   logic [1:0]  load_pal_i;
   logic [7:0]  load_key_i;
   logic        wr_valid_i;
   logic [23:0] wr_rgb_i;
   logic        wr_ready_o;
   logic        load_busy_o;
   logic [3:0]  pal_loaded_o;

   always #5 clk = ~clk;

   palette_lut_pipe #(
      .IDX_W   (8),
      .NUM_PAL (4)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .pix_valid_i  (pix_valid_i),
      .pix_pal_i    (pix_pal_i),
      .pix_idx_i    (pix_idx_i),
      .pix_valid_o  (pix_valid_o),
      .pix_rgb_o    (pix_rgb_o),
      .pix_transp_o (pix_transp_o),
      .load_start_i (load_start_i),
      .load_pal_i   (load_pal_i),
      .load_key_i   (load_key_i),
      .wr_valid_i   (wr_valid_i),
      .wr_rgb_i     (wr_rgb_i),
      .wr_ready_o   (wr_ready_o),
      .load_busy_o  (load_busy_o),
      .pal_loaded_o (pal_loaded_o)
   );

   typedef struct packed {
      logic        v;
      logic        t;
      logic [23:0] rgb;
   } exp_t;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [23:0] m_mem [4][256];
   logic [7:0]  m_key [4];
   logic [3:0]  m_loaded;
   logic        m_busy;
   logic [1:0]  m_cur;
   logic [7:0]  m_addr;
   exp_t        e1;
   exp_t        e2;

   task automatic expect_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] data_for(input int kind, input int i);
      logic [7:0] b;
      b = i[7:0];
      return (kind == 0) ? {b, ~b, 8'h5a} : {~b, b, 8'ha5};
   endfunction

   function automatic exp_t lookup(input logic v, input logic [1:0] p,
                                   input logic [7:0] i);
      exp_t r;
      r.v = v;
      if (m_loaded[p]) begin
         r.rgb = m_mem[p][i];
         r.t   = (i == m_key[p]);
      end else begin
         r.rgb = {i, i, i};
         r.t   = 1'b0;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_loaded = '0;
      m_busy   = 1'b0;
      m_cur    = '0;
      m_addr   = '0;
      for (int i = 0; i < 4; i++) m_key[i] = '0;
      e1 = '0;
      e2 = '0;
   endtask

   task automatic model_step();
      if (!m_busy) begin
         if (load_start_i) begin
            m_key[load_pal_i]    = load_key_i;
            m_loaded[load_pal_i] = 1'b0;
            m_cur  = load_pal_i;
            m_addr = '0;
            m_busy = 1'b1;
         end
      end else if (wr_valid_i) begin
         m_mem[m_cur][m_addr] = wr_rgb_i;
         if (m_addr == 8'hff) begin
            m_loaded[m_cur] = 1'b1;
            m_busy = 1'b0;
         end
         m_addr = m_addr + 8'd1;
      end
   endtask

   task automatic cycle();
      exp_t nw;
      nw = lookup(pix_valid_i, pix_pal_i, pix_idx_i);
      model_step();
      @(posedge clk);
      #1;
      e2 = e1;
      e1 = nw;
      expect_eq("valid", pix_valid_o, e2.v);
      if (e2.v) begin
         expect_eq("rgb", pix_rgb_o, e2.rgb);
         expect_eq("transp", pix_transp_o, e2.t);
      end
      expect_eq("loaded", pal_loaded_o, m_loaded);
      expect_eq("busy", load_busy_o, m_busy);
      expect_eq("ready", wr_ready_o, m_busy);
   endtask

   task automatic set_look(input int lp);
      if (lp >= 0) begin
         pix_valid_i = 1'b1;
         pix_pal_i   = lp[1:0];
         pix_idx_i   = 8'($urandom_range(0, 255));
      end else begin
         pix_valid_i = 1'b0;
      end
   endtask

   task automatic idle_inputs();
      pix_valid_i  = 1'b0;
      load_start_i = 1'b0;
      wr_valid_i   = 1'b0;
   endtask

   task automatic look(input logic [1:0] p, input logic [7:0] i);
      pix_valid_i = 1'b1;
      pix_pal_i   = p;
      pix_idx_i   = i;
      cycle();
      pix_valid_i = 1'b0;
   endtask

   task automatic load(input logic [1:0] pal, input logic [7:0] k,
                       input int kind, input int look_pal,
                       input int inj_beat, input int rst_beat);
      int   beat;
      logic acc;
      logic injected;
      beat = 0;
      injected = 1'b0;
      load_start_i = 1'b1;
      load_pal_i   = pal;
      load_key_i   = k;
      set_look(look_pal);
      cycle();
      load_start_i = 1'b0;
      for (int g = 0; g < 4000 && beat < 256; g++) begin
         if (beat == rst_beat) begin
            #1;
            reset_n = 1'b0;
            #1;
            expect_eq("rst_valid", pix_valid_o, 1'b0);
            expect_eq("rst_rgb", pix_rgb_o, 24'h0);
            expect_eq("rst_transp", pix_transp_o, 1'b0);
            expect_eq("rst_loaded", pal_loaded_o, 4'h0);
            expect_eq("rst_ready", wr_ready_o, 1'b0);
            expect_eq("rst_busy", load_busy_o, 1'b0);
            model_reset();
            idle_inputs();
            @(negedge clk);
            reset_n = 1'b1;
            cycle();
            return;
         end
         wr_valid_i = ($urandom_range(0, 3) != 0);
         wr_rgb_i   = data_for(kind, beat);
         if (beat == inj_beat && !injected) begin
            injected     = 1'b1;
            load_start_i = 1'b1;
            load_pal_i   = 2'd2;
            load_key_i   = 8'h33;
         end
         set_look(look_pal);
         acc = wr_valid_i;
         cycle();
         load_start_i = 1'b0;
         if (acc) beat++;
      end
      idle_inputs();
      cycle();
      expect_eq("loaded_bit", pal_loaded_o[pal], 1'b1);
   endtask

   initial begin
      reset_n      = 1'b0;
      pix_pal_i    = '0;
      pix_idx_i    = '0;
      load_pal_i   = '0;
      load_key_i   = '0;
      wr_rgb_i     = '0;
      idle_inputs();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      expect_eq("init_valid", pix_valid_o, 1'b0);
      expect_eq("init_rgb", pix_rgb_o, 24'h0);
      expect_eq("init_transp", pix_transp_o, 1'b0);
      expect_eq("init_loaded", pal_loaded_o, 4'h0);
      expect_eq("init_ready", wr_ready_o, 1'b0);
      expect_eq("init_busy", load_busy_o, 1'b0);
      reset_n = 1'b1;

      look(2'd0, 8'h8b);
      cycle();
      expect_eq("grey_8b", pix_rgb_o, 24'h8b8b8b);
      expect_eq("grey_8b_t", pix_transp_o, 1'b0);
      expect_eq("grey_8b_ld", pal_loaded_o, 4'h0);

      load(2'd1, 8'h00, 0, -1, -1, -1);
      look(2'd1, 8'h76);
      look(2'd1, 8'h00);
      expect_eq("p1_76_rgb", pix_rgb_o, 24'h76895a);
      expect_eq("p1_76_t", pix_transp_o, 1'b0);
      cycle();
      expect_eq("p1_00_rgb", pix_rgb_o, 24'h00ff5a);
      expect_eq("p1_00_t", pix_transp_o, 1'b1);

      for (int i = 0; i < 40; i++) begin
         set_look(i % 2);
         cycle();
      end
      for (int i = 0; i < 30; i++) begin
         set_look(($urandom_range(0, 1) != 0) ? (i % 2) : -1);
         cycle();
      end
      idle_inputs();
      cycle();

      load(2'd1, 8'h20, 1, 1, -1, -1);
      for (int i = 0; i < 20; i++) begin
         set_look(i % 2);
         cycle();
      end
      look(2'd1, 8'h76);
      cycle();
      expect_eq("p1_new_rgb", pix_rgb_o, 24'h8976a5);
      look(2'd1, 8'h20);
      cycle();
      expect_eq("p1_new_key", pix_transp_o, 1'b1);
      look(2'd0, 8'h3c);
      cycle();
      expect_eq("p0_grey", pix_rgb_o, 24'h3c3c3c);

      load(2'd1, 8'h44, 0, 0, 50, -1);
      expect_eq("inj_loaded", pal_loaded_o, 4'b0010);
      look(2'd1, 8'h44);
      cycle();
      expect_eq("inj_rgb", pix_rgb_o, 24'h44bb5a);
      expect_eq("inj_key", pix_transp_o, 1'b1);
      look(2'd1, 8'h33);
      cycle();
      expect_eq("inj_key33", pix_transp_o, 1'b0);

      load(2'd3, 8'h11, 1, 1, -1, 100);
      expect_eq("post_rst_ld", pal_loaded_o, 4'h0);
      load(2'd1, 8'h10, 1, 0, -1, -1);
      look(2'd1, 8'h10);
      cycle();
      expect_eq("fresh_rgb", pix_rgb_o, 24'hef10a5);
      expect_eq("fresh_t", pix_transp_o, 1'b1);
      look(2'd3, 8'h05);
      cycle();
      expect_eq("p3_grey", pix_rgb_o, 24'h050505);
      expect_eq("p3_t", pix_transp_o, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/palette_lut_pipe.md
Name: palette_lut_pipe

Overview:
- Parametrised, pipelined successor to the fixed sprite colour maps: NUM_PAL independent palettes of 2^IDX_W 24-bit RGB entries each, held in a single inferred synchronous RAM.
- Palettes are loaded at runtime through a streaming write port driven by a small load FSM.
- Sits between the sprite ROM index readers and the VGA colour mux. Converts {palette id, pixel index} to RGB plus a per-palette transparency flag, with fixed 2-cycle latency.

Parameters:
- IDX_W, 8: pixel index width; each palette has 2^IDX_W entries.
- NUM_PAL, 4: number of palettes; must be ≥2.
- PAL_W, $clog2(NUM_PAL): palette id width. Localparam, derived, not overridable.

Ports:
- Clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pix_valid_i  in  1  pixel lookup request this cycle
- pix_pal_i  in  PAL_W  palette selector
- pix_idx_i  in  IDX_W  colour index
- pix_valid_o  out  1  pix_valid_i delayed 2 cycles
- pix_rgb_o  out  24  looked-up colour {R,G,B}
- pix_transp_o  out  1  pixel is the palette's transparency key
- load_start_i  in  1  begin loading palette load_pal_i (IDLE only)
- load_pal_i  in  PAL_W  palette to load
- load_key_i  in  IDX_W  transparency key index for that palette
- wr_valid_i  in  1  RGB beat offered
- wr_rgb_i  in  24  RGB beat data, entry order 0..2^IDX_W-1
- wr_ready_o  out  1  beat accepted when wr_valid_i & wr_ready_o
- load_busy_o  out  1  FSM in LOAD
- pal_loaded_o  out  NUM_PAL  bit p = palette p fully loaded

Behaviour:
- Reset (async assert, sync release). All outputs 0, FSM = IDLE, loaded bits 0, key registers 0, address counter 0. RAM contents are not reset.
- Lookup pipeline, no backpressure; a request is accepted every cycle.
  - S1: register valid, pal, idx. Issue RAM read at address {pal,idx}. Sample loaded[pal] and key[pal].
  - S2: register outputs.
  - Request at edge N appears on outputs after edge N+2.
- pix_rgb_o:
  - Loaded palette: RAM data.
  - Unloaded palette: greyscale fallback {idx,idx,idx} (e.g. idx 8'h40 → 24'h404040).
- pix_transp_o = loaded sample AND idx == key sample. Always 0 for an unloaded palette.
- Outputs when pix_valid_o = 0: rgb and transp hold their previous values. Bench must not check them.
- FSM IDLE:
  - wr_ready_o = 0; wr_valid_i is ignored.
  - On load_start_i: latch pal into cur_pal and write key[load_pal_i] = load_key_i. Clear loaded[load_pal_i] the same edge; other palettes are unaffected. Set addr = 0 and go to LOAD.
- FSM LOAD:
  - wr_ready_o = 1 and load_busy_o = 1.
  - Each accepted beat writes RAM[{cur_pal,addr}] = wr_rgb_i and increments addr.
  - Beat with addr = 2^IDX_W-1: set loaded[cur_pal], wrap addr to 0, return to IDLE. wr_ready_o is 0 from the next cycle.
  - load_start_i in LOAD is ignored; cur_pal and key are unchanged.
  - Gaps (wr_valid_i = 0) are allowed indefinitely; no timeout.
- Read/write to the same address in the same cycle: read-first (old data returned). The palette being loaded reads as fallback anyway, since its loaded bit is clear.
- Reset mid-load: FSM → IDLE, all loaded bits cleared, partial data is left in RAM but unused.
- Arithmetic: addr is IDX_W bits and wraps naturally. RAM depth = NUM_PAL·2^IDX_W, address = {pal,idx}, PAL_W+IDX_W bits. pix_pal_i ≥ NUM_PAL (non-power-of-2 NUM_PAL) → treated as unloaded (fallback, transp 0).

Decomposition:
- Shared package palette_pkg:
  - rgb_t (24-bit packed struct r,g,b)
  - FSM enum {PL_IDLE, PL_LOAD}
  - constants TRANSP_NONE, GREY_FALLBACK function
- One sub-module: palette_ram, simple dual-port (1 write, 1 sync read), read-first, parametrised on depth/width, BRAM-inferable.
- FSM and pipeline stay in the top.

Test Plan:
- Reset then lookup pal 0 idx 8'h8b → after 2 cycles rgb 24'h8b8b8b, transp 0, pal_loaded_o 0.
- Load pal 1, key 8'h00, data RAM[i] = {i, ~i, 8'h5a} with 256 beats and random wr_valid gaps:
  - load_busy_o is high throughout; pal_loaded_o[1] rises after the final beat.
  - Lookup pal 1 idx 8'h76 → 24'h76895a, transp 0; idx 8'h00 → transp 1.
- Back-to-back lookups every cycle, alternating pal 0/1 → outputs match the 2-cycle-delayed model with no bubbles; pix_valid_o tracks input exactly.
- Reload pal 1 while streaming lookups to pal 1 → fallback grey from the cycle after load_start_i until the final beat; new data afterwards. Pal 0 is unaffected.
- Assert load_start_i (pal 2) mid-load of pal 1 → ignored; beats keep filling pal 1; key[2] unchanged.
- Pulse reset_n low at beat 100 of a load → all outputs 0 immediately, pal_loaded_o = 0, FSM IDLE, wr_ready_o 0; a fresh full load then succeeds.
